// File: rtl/fpu_dispatcher.sv
// fpu_dispatcher: accepts one FP request, runs it on one of four external
// arithmetic units (add, mul, div, cvt) or evaluates feq/flt/fle in place,
// and returns the result over a stb/ack response channel. Every unit
// transaction is guarded by a cycle timeout that latches a sticky fault.
module fpu_dispatcher #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1),
  parameter bit EN_CMP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       op,
  input  logic [31:0]      in1,
  input  logic [31:0]      in2,
  input  logic             req_stb,
  output logic             req_ack,
  output logic [31:0]      out,
  output logic             out_err,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             fault,
  output logic [3:0][31:0] unit_a,
  output logic [3:0][31:0] unit_b,
  output logic [3:0]       unit_a_stb,
  output logic [3:0]       unit_b_stb,
  input  logic [3:0]       unit_a_ack,
  input  logic [3:0]       unit_b_ack,
  output logic             unit_mode,
  input  logic [3:0][31:0] unit_z,
  input  logic [3:0]       unit_z_stb,
  output logic [3:0]       unit_z_ack
);

  // Counter is at least one bit wide so TIMEOUT=0 (disabled) still elaborates.
  localparam int CW = (CNT_W > 0) ? CNT_W : 1;

  localparam logic [3:0] OP_FSUB = 4'b0001;
  localparam logic [3:0] OP_FEQ  = 4'b0110;
  localparam logic [3:0] OP_FLT  = 4'b0111;
  localparam logic [3:0] OP_FLE  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_CMP,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [3:0]      r_op;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [1:0]      r_unit;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_out;
  logic            r_err;

  logic            w_a_nan;
  logic            w_b_nan;
  logic            w_both_zero;
  logic            w_eq;
  logic            w_lt;
  logic            w_cmp;
  logic            w_timeout;
  logic            w_a_seen;
  logic            w_b_seen;

  // Ops 0000..0101 run on an external unit.
  function automatic logic is_unit_op(input logic [3:0] o);
    return o <= 4'b0101;
  endfunction

  function automatic logic is_cmp_op(input logic [3:0] o);
    return EN_CMP && (o == OP_FEQ || o == OP_FLT || o == OP_FLE);
  endfunction

  // Unit index: 0 add/sub, 1 mul, 2 div, 3 cvt (both directions).
  function automatic logic [1:0] unit_of(input logic [3:0] o);
    case (o)
      4'b0000, 4'b0001: return 2'd0;
      4'b0010:          return 2'd1;
      4'b0011:          return 2'd2;
      default:          return 2'd3;
    endcase
  endfunction

  // Every unit sees the latched operands; only the selected one is strobed.
  assign unit_a    = {4{r_a}};
  assign unit_b    = {4{r_b}};
  assign unit_mode = r_op[0];
  assign out       = r_out;
  assign out_err   = r_err;

  // An operand strobe counts as delivered once it has dropped or is being acked now.
  assign w_a_seen  = !unit_a_stb[r_unit] || unit_a_ack[r_unit];
  assign w_b_seen  = !unit_b_stb[r_unit] || unit_b_ack[r_unit];
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  // IEEE compare of the latched operands: sign-magnitude order, +0 == -0, NaN false.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case leaves a signal unassigned and infers a latch.
    w_cmp       = 1'b0;
    w_a_nan     = (&r_a[30:23]) && (|r_a[22:0]);
    w_b_nan     = (&r_b[30:23]) && (|r_b[22:0]);
    w_both_zero = (r_a[30:0] == 31'd0) && (r_b[30:0] == 31'd0);
    w_eq        = (r_a == r_b) || w_both_zero;
    if (w_both_zero)
      w_lt = 1'b0;
    else if (r_a[31] != r_b[31])
      w_lt = r_a[31];
    else if (r_a[31])
      w_lt = r_a[30:0] > r_b[30:0];
    else
      w_lt = r_a[30:0] < r_b[30:0];
    if (!(w_a_nan || w_b_nan)) begin
      case (r_op)
        OP_FEQ:  w_cmp = w_eq;
        OP_FLT:  w_cmp = w_lt;
        OP_FLE:  w_cmp = w_lt || w_eq;
        default: w_cmp = 1'b0;
      endcase
    end
  end

  // Control FSM: request intake, unit handshakes, timeout guard, response hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_op       <= 4'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_unit     <= 2'd0;
      r_cnt      <= '0;
      r_out      <= 32'd0;
      r_err      <= 1'b0;
      req_ack    <= 1'b0;
      out_stb    <= 1'b0;
      fault      <= 1'b0;
      unit_a_stb <= 4'd0;
      unit_b_stb <= 4'd0;
      unit_z_ack <= 4'd0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values; a later assignment to the same register wins.
      req_ack    <= 1'b0;
      unit_z_ack <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (req_stb && !fault) begin
            req_ack <= 1'b1;
            r_op    <= op;
            r_a     <= in1;
            r_b     <= (op == OP_FSUB) ? {~in2[31], in2[30:0]} : in2;
            r_unit  <= unit_of(op);
            r_cnt   <= '0;
            r_out   <= 32'd0;
            r_err   <= 1'b0;
            if (is_unit_op(op)) begin
              unit_a_stb <= 4'b0001 << unit_of(op);
              unit_b_stb <= 4'b0001 << unit_of(op);
              r_state    <= S_SEND;
            end else begin
              // Illegal ops share the one-cycle CMP slot so every internal
              // op answers with the same latency; r_err suppresses the result.
              r_err   <= !is_cmp_op(op);
              r_state <= S_CMP;
            end
          end
        end

        S_SEND: begin
          if (w_timeout) begin
            unit_a_stb <= 4'd0;
            unit_b_stb <= 4'd0;
            fault      <= 1'b1;
            r_err      <= 1'b1;
            r_out      <= 32'd0;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (unit_a_ack[r_unit]) unit_a_stb[r_unit] <= 1'b0;
            if (unit_b_ack[r_unit]) unit_b_stb[r_unit] <= 1'b0;
            if (w_a_seen && w_b_seen) r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (unit_z_stb[r_unit]) begin
            r_out      <= unit_z[r_unit];
            r_err      <= 1'b0;
            unit_z_ack <= 4'b0001 << r_unit;
            r_state    <= S_RESP;
          end else if (w_timeout) begin
            fault   <= 1'b1;
            r_err   <= 1'b1;
            r_out   <= 32'd0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_CMP: begin
          if (!r_err) r_out <= {31'd0, w_cmp};
          r_state <= S_RESP;
        end

        S_RESP: begin
          if (out_stb && out_ack) begin
            out_stb <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            out_stb <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dispatcher.sv
// Directed bench for fpu_dispatcher: table of internal (compare/illegal) ops,
// table of unit ops served by a procedural unit stub, plus hand-written
// sequences for response hold, timeout/fault and mid-operation reset.
module tb_fpu_dispatcher;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       op;
  logic [31:0]      in1, in2;
  logic             req_stb;
  logic             req_ack;
  logic [31:0]      out;
  logic             out_err, out_stb, out_ack;
  logic             fault;
  logic [3:0][31:0] unit_a, unit_b;
  logic [3:0]       unit_a_stb, unit_b_stb;
  logic [3:0]       unit_a_ack, unit_b_ack;
  logic             unit_mode;
  logic [3:0][31:0] unit_z;
  logic [3:0]       unit_z_stb;
  logic [3:0]       unit_z_ack;

  int checks = 0;
  int failures = 0;

  fpu_dispatcher #(.TIMEOUT(16), .EN_CMP(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .in1(in1), .in2(in2),
    .req_stb(req_stb), .req_ack(req_ack), .out(out), .out_err(out_err),
    .out_stb(out_stb), .out_ack(out_ack), .fault(fault),
    .unit_a(unit_a), .unit_b(unit_b), .unit_a_stb(unit_a_stb),
    .unit_b_stb(unit_b_stb), .unit_a_ack(unit_a_ack), .unit_b_ack(unit_b_ack),
    .unit_mode(unit_mode), .unit_z(unit_z), .unit_z_stb(unit_z_stb),
    .unit_z_ack(unit_z_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x, y;
    logic [31:0] exp_out;
    logic        exp_err;
  } int_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x, y;
    int          u;
    logic [31:0] exp_b;
    logic        exp_mode;
    int          a_dly, b_dly, z_dly;
    logic [31:0] zval;
  } unit_vec_t;

  int_vec_t  iv[13];
  unit_vec_t uv[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_req(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string nm);
    @(negedge clk);
    op = o; in1 = x; in2 = y; req_stb = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ack) break;
    end
    check({nm, " req_ack"}, req_ack, 1);
    req_stb = 1'b0; op = 4'hF; in1 = 32'hDEADBEEF; in2 = 32'hDEADBEEF;
  endtask

  task automatic wait_out(input string nm);
    for (int n = 0; n < 30; n++) begin
      if (out_stb) break;
      @(negedge clk);
    end
    check({nm, " out_stb"}, out_stb, 1);
  endtask

  task automatic ack_out(input string nm);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    check({nm, " out_stb drop"}, out_stb, 0);
  endtask

  task automatic run_int(input int_vec_t v, input string nm);
    int n;
    send_req(v.op, v.x, v.y, nm);
    check({nm, " no unit strobe"}, {unit_a_stb, unit_b_stb}, 0);
    n = 0;
    while (!out_stb && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, n, 2);
    check({nm, " out"}, out, v.exp_out);
    check({nm, " out_err"}, out_err, v.exp_err);
    ack_out(nm);
  endtask

  task automatic run_unit(input unit_vec_t v, input string nm);
    logic [3:0] m;
    bit sent, zgiven, other;
    int tsent, zp;
    m = 4'b0001 << v.u;
    send_req(v.op, v.x, v.y, nm);
    check({nm, " a_stb"}, unit_a_stb, m);
    check({nm, " b_stb"}, unit_b_stb, m);
    check({nm, " unit_a"}, unit_a[v.u], v.x);
    check({nm, " unit_b"}, unit_b[v.u], v.exp_b);
    if (v.u == 3) check({nm, " unit_mode"}, unit_mode, v.exp_mode);
    // Decoy results on every other unit must be ignored.
    for (int i = 0; i < 4; i++) unit_z[i] = 32'hBAD00000 | i;
    unit_z_stb = ~m;
    sent = 0; zgiven = 0; other = 0; tsent = 0; zp = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_stb) break;
      if ((unit_z_ack & ~m) != 4'd0) other = 1;
      if (unit_z_ack[v.u]) begin
        zp++;
        unit_z_stb[v.u] = 1'b0;
        zgiven = 1;
      end
      if (!sent && unit_a_stb == 4'd0 && unit_b_stb == 4'd0) begin
        sent = 1;
        tsent = c;
      end
      unit_a_ack = (c >= v.a_dly) ? unit_a_stb : 4'd0;
      unit_b_ack = (c >= v.b_dly) ? unit_b_stb : 4'd0;
      if (sent && !zgiven && c >= tsent + v.z_dly) begin
        unit_z[v.u] = v.zval;
        unit_z_stb[v.u] = 1'b1;
      end
      @(negedge clk);
    end
    check({nm, " out_stb"}, out_stb, 1);
    check({nm, " out"}, out, v.zval);
    check({nm, " out_err"}, out_err, 0);
    check({nm, " z_ack pulses"}, zp, 1);
    check({nm, " foreign z_ack"}, other, 0);
    unit_z_stb = 4'd0; unit_a_ack = 4'd0; unit_b_ack = 4'd0;
    ack_out(nm);
  endtask

  initial begin
    int n, acks;
    int_vec_t hv;

    iv[0]  = '{4'b0110, 32'h00000000, 32'h80000000, 32'd1, 1'b0};
    iv[1]  = '{4'b0111, 32'h7FC00000, 32'h3F800000, 32'd0, 1'b0};
    iv[2]  = '{4'b1000, 32'hBF800000, 32'h3F800000, 32'd1, 1'b0};
    iv[3]  = '{4'b0110, 32'h3F800000, 32'h3F800000, 32'd1, 1'b0};
    iv[4]  = '{4'b0110, 32'h3F800000, 32'h40000000, 32'd0, 1'b0};
    iv[5]  = '{4'b0111, 32'h80000000, 32'h00000000, 32'd0, 1'b0};
    iv[6]  = '{4'b1000, 32'h80000000, 32'h00000000, 32'd1, 1'b0};
    iv[7]  = '{4'b0111, 32'hC0000000, 32'hBF800000, 32'd1, 1'b0};
    iv[8]  = '{4'b0111, 32'h3F800000, 32'h3F800000, 32'd0, 1'b0};
    iv[9]  = '{4'b0110, 32'h7FC00000, 32'h7FC00000, 32'd0, 1'b0};
    iv[10] = '{4'b1000, 32'h7F800000, 32'h7F800000, 32'd1, 1'b0};
    iv[11] = '{4'b1010, 32'h00000001, 32'h00000002, 32'd0, 1'b1};
    iv[12] = '{4'b1111, 32'h3F800000, 32'h3F800000, 32'd0, 1'b1};

    uv[0] = '{4'b0000, 32'h3F800000, 32'h40000000, 0, 32'h40000000, 1'b0, 0, 0, 1, 32'h40400000};
    uv[1] = '{4'b0001, 32'h3F800000, 32'h40000000, 0, 32'hC0000000, 1'b0, 3, 1, 0, 32'hBF800000};
    uv[2] = '{4'b0001, 32'h3F800000, 32'hC0000000, 0, 32'h40000000, 1'b0, 0, 0, 0, 32'h40400000};
    uv[3] = '{4'b0010, 32'h40000000, 32'h40400000, 1, 32'h40400000, 1'b0, 1, 1, 0, 32'h40C00000};
    uv[4] = '{4'b0011, 32'h40C00000, 32'h40000000, 2, 32'h40000000, 1'b0, 0, 2, 3, 32'h40400000};
    uv[5] = '{4'b0100, 32'h00000005, 32'h00000000, 3, 32'h00000000, 1'b0, 1, 0, 2, 32'h40A00000};

    reset_n = 1'b0; op = 4'd0; in1 = 32'd0; in2 = 32'd0; req_stb = 1'b0; out_ack = 1'b0;
    unit_a_ack = 4'd0; unit_b_ack = 4'd0; unit_z = '0; unit_z_stb = 4'd0;
    repeat (3) @(negedge clk);
    check("rst req_ack", req_ack, 0);
    check("rst out_stb", out_stb, 0);
    check("rst out", out, 0);
    check("rst out_err", out_err, 0);
    check("rst fault", fault, 0);
    check("rst strobes", {unit_a_stb, unit_b_stb, unit_z_ack}, 0);
    check("rst unit_a0", unit_a[0], 0);
    check("rst unit_mode", unit_mode, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) run_int(iv[i], $sformatf("int%0d", i));
    for (int i = 0; i < 6; i++) run_unit(uv[i], $sformatf("unit%0d", i));

    // Response held while out_ack stays low; no new acceptance meanwhile.
    send_req(4'b1010, 32'h1, 32'h2, "hold");
    wait_out("hold");
    check("hold out_err", out_err, 1);
    check("hold out", out, 0);
    op = 4'b0110; in1 = 32'h0; in2 = 32'h0; req_stb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d out_stb", k), out_stb, 1);
      check($sformatf("hold%0d req_ack", k), req_ack, 0);
    end
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    check("hold release out_stb", out_stb, 0);
    check("hold no same-cycle ack", req_ack, 0);
    @(negedge clk);
    check("hold next req_ack", req_ack, 1);
    req_stb = 1'b0;
    wait_out("hold feq");
    check("hold feq out", out, 1);
    ack_out("hold feq");

    // Timeout: operand A never acked, no result; abort after 16 SEND+WAIT cycles.
    send_req(4'b0010, 32'h3F800000, 32'h3F800000, "tmo");
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (fault) break;
      unit_b_ack = unit_b_stb;
      n++;
      @(negedge clk);
    end
    unit_b_ack = 4'd0;
    check("tmo fault", fault, 1);
    check("tmo cycles", n, 16);
    check("tmo strobes dropped", {unit_a_stb, unit_b_stb}, 0);
    wait_out("tmo");
    check("tmo out_err", out_err, 1);
    check("tmo out", out, 0);
    ack_out("tmo");
    req_stb = 1'b1; op = 4'b0000; acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_ack) acks++;
    end
    req_stb = 1'b0;
    check("tmo no ack while fault", acks, 0);
    check("tmo fault sticky", fault, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("tmo reset clears fault", fault, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_unit(uv[0], "post_tmo fadd");

    // Reset during WAIT of fdiv aborts asynchronously.
    send_req(4'b0011, 32'h40C00000, 32'h40000000, "rstw");
    for (int c = 0; c < 10; c++) begin
      unit_a_ack = unit_a_stb;
      unit_b_ack = unit_b_stb;
      @(negedge clk);
      if (unit_a_stb == 4'd0 && unit_b_stb == 4'd0) break;
    end
    unit_a_ack = 4'd0; unit_b_ack = 4'd0;
    check("rstw in WAIT unit_a2", unit_a[2], 32'h40C00000);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rstw strobes", {unit_a_stb, unit_b_stb, unit_z_ack}, 0);
    check("rstw req_ack/out_stb/err", {req_ack, out_stb, out_err, fault}, 0);
    check("rstw unit_a2", unit_a[2], 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_unit('{4'b0101, 32'h3F800000, 32'h00000000, 3, 32'h00000000, 1'b1, 0, 0, 1, 32'h00000001},
             "cvt_ws");

    // Compare again after everything to confirm clean return to IDLE.
    hv = '{4'b1000, 32'h40000000, 32'h3F800000, 32'd0, 1'b0};
    run_int(hv, "final fle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
